// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - common-anode 7-segment scanner with double-buffered digit codes
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (digit0 always shown).
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   din,
  output logic [3:0]                bin,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_done
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]               pre_q, pre_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           pending_q, pending_d;
  logic [NUM_DIGITS-1:0][3:0]     shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]     active_q, active_d;
  logic [NUM_DIGITS-1:0][3:0]     disp;
  logic [3:0]                     bin_q, bin_d;
  logic [NUM_DIGITS-1:0]          sel_q, sel_d;
  logic                           frame_done_q, frame_done_d;
  logic                           pre_wrap, boundary;

  assign pre_wrap = (pre_q == PRE_LAST);
  assign boundary = pre_wrap && (idx_q == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  // Walk from the most significant digit; zeros stay blank until a non-zero is seen.
  always_comb begin
    disp = active_q;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (lead && (i != 0) && (active_q[i] == 4'h0)) disp[i] = 4'hF;
      if (active_q[i] != 4'h0) lead = 1'b0;
    end
  end
`else
  assign disp = active_q;
`endif

  always_comb begin
    pre_d     = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d     = idx_q;
    if (pre_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    // A load landing on the boundary bypasses the shadow so the next frame is never stale.
    if (load) begin
      shadow_d = din;
      if (boundary) begin
        active_d  = din;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    if (pre_q < BLANK_END) begin
      sel_d = '1;
      bin_d = 4'hF;
    end else begin
      sel_d = ~(NUM_DIGITS'(1) << idx_q);
      bin_d = disp[idx_q];
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '1;
      active_q     <= '1;
      bin_q        <= 4'hF;
      sel_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      bin_q        <= bin_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bin        = bin_q;
  assign digit_sel  = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed bench for seg_scan_mux (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2)
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] din;
  logic [3:0]  bin;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int pass_cnt = 0;
  int total    = 0;
  logic [8:0] obs [1:32];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] E0040 = 16'hFF40;
  localparam logic [15:0] E0000 = 16'hFFF0;
`else
  localparam logic [15:0] E0040 = 16'h0040;
  localparam logic [15:0] E0000 = 16'h0000;
`endif

  seg_scan_mux #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .din(din),
    .bin(bin), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Expected {digit_sel, bin, frame_done} for cycle j (1..32) of a frame showing d.
  function automatic logic [8:0] expv(input logic [15:0] d, input int j);
    int c, s;
    logic [3:0] sel, b;
    c = j - 1;
    s = c / 8;
    if ((c % 8) < 2) begin
      sel = 4'hF;
      b   = 4'hF;
    end else begin
      sel = ~(4'b0001 << s);
      b   = d[4*s +: 4];
    end
    return {sel, b, (j == 32)};
  endfunction

  // Runs one 32-cycle frame from counter state 0/0, pulsing load at up to two cycles.
  task automatic run_frame(input int la1, input logic [15:0] v1,
                           input int la2, input logic [15:0] v2);
    for (int j = 1; j <= 32; j++) begin
      load = (j == la1) || (j == la2);
      din  = (j == la2) ? v2 : v1;
      @(posedge clk);
      @(negedge clk);
      obs[j] = {digit_sel, bin, frame_done};
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load  = 1'b1;
    din   = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({digit_sel, bin, frame_done} !== {4'hF, 4'hF, 1'b0})
        $display("FAIL reset cyc %0d: got %b, expected %b", k, {digit_sel, bin, frame_done}, {4'hF, 4'hF, 1'b0});
      else pass_cnt++;
    end
    rst_n = 1'b1;
    load  = 1'b0;
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'hFFFF, j))
        $display("FAIL reset_first_frame cyc %0d: got %b, expected %b", j, obs[j], expv(16'hFFFF, j));
      else pass_cnt++;
    end
  endtask

  task automatic test_load_frame;
    run_frame(1, 16'h1234, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'hFFFF, j))
        $display("FAIL load_pending_frame cyc %0d: got %b, expected %b", j, obs[j], expv(16'hFFFF, j));
      else pass_cnt++;
    end
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 16'h0, -1, 16'h0);
      for (int j = 1; j <= 32; j++) begin
        total++;
        if (obs[j] !== expv(16'h1234, j))
          $display("FAIL load_1234 frame %0d cyc %0d: got %b, expected %b", f, j, obs[j], expv(16'h1234, j));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_mid_frame_load;
    run_frame(12, 16'h5678, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h1234, j))
        $display("FAIL mid_load_no_tear cyc %0d: got %b, expected %b", j, obs[j], expv(16'h1234, j));
      else pass_cnt++;
    end
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h5678, j))
        $display("FAIL mid_load_next cyc %0d: got %b, expected %b", j, obs[j], expv(16'h5678, j));
      else pass_cnt++;
    end
  endtask

  task automatic test_boundary_load;
    run_frame(32, 16'h9A00, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h5678, j))
        $display("FAIL boundary_load_cur cyc %0d: got %b, expected %b", j, obs[j], expv(16'h5678, j));
      else pass_cnt++;
    end
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h9A00, j))
        $display("FAIL boundary_load_next cyc %0d: got %b, expected %b", j, obs[j], expv(16'h9A00, j));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    run_frame(5, 16'h1111, 6, 16'h2222);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h9A00, j))
        $display("FAIL b2b_cur cyc %0d: got %b, expected %b", j, obs[j], expv(16'h9A00, j));
      else pass_cnt++;
    end
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(16'h2222, j))
        $display("FAIL b2b_last_wins cyc %0d: got %b, expected %b", j, obs[j], expv(16'h2222, j));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame;
    // Advance into digit2 slot with a load pending, then reset for one cycle.
    for (int k = 1; k <= 19; k++) begin
      load = (k == 10);
      din  = 16'h1111;
      @(posedge clk);
      @(negedge clk);
    end
    load  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({digit_sel, bin, frame_done} !== {4'hF, 4'hF, 1'b0})
      $display("FAIL mid_reset_outputs: got %b, expected %b", {digit_sel, bin, frame_done}, {4'hF, 4'hF, 1'b0});
    else pass_cnt++;
    rst_n = 1'b1;
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, 16'h0, -1, 16'h0);
      for (int j = 1; j <= 32; j++) begin
        total++;
        if (obs[j] !== expv(16'hFFFF, j))
          $display("FAIL mid_reset_frame %0d cyc %0d: got %b, expected %b", f, j, obs[j], expv(16'hFFFF, j));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_leading_zero;
    run_frame(1, 16'h0040, -1, 16'h0);
    run_frame(1, 16'h0000, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(E0040, j))
        $display("FAIL lzb_0040 cyc %0d: got %b, expected %b", j, obs[j], expv(E0040, j));
      else pass_cnt++;
    end
    run_frame(-1, 16'h0, -1, 16'h0);
    for (int j = 1; j <= 32; j++) begin
      total++;
      if (obs[j] !== expv(E0000, j))
        $display("FAIL lzb_0000 cyc %0d: got %b, expected %b", j, obs[j], expv(E0000, j));
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    din   = 16'h0;
    @(negedge clk);
    test_reset();
    test_load_frame();
    test_mid_frame_load();
    test_boundary_load();
    test_back_to_back();
    test_reset_mid_frame();
    test_leading_zero();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
